// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: bubble encoding, PC step and FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // J/JAL target: keep the upper nibble of the delay-slot PC, word-align the index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous load of RESET_PC on rst, otherwise loads
// pc_d_i unless hold_i is asserted.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (!hold_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and BOOT/RUN sequencing.
// Optional stall/flush performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic [25:0] jumpIndex,
  input  logic [31:0] jrTarget,
  output logic [31:0] instAddr,
  input  logic [31:0] instIn,
  output logic [31:0] ifId_inst,
  output logic [31:0] ifId_pcPlus4,
  output logic        ifId_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         pc_hold;

  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;

  assign pc_plus4 = pc + PC_INC;

  // Only a valid instruction in ID may redirect; a bubble carries no decision.
  assign redirect = valid_q & (jumpReg | jump | branchTaken);

  always_comb begin
    next_pc = pc_plus4;
    if (jumpReg) begin
      next_pc = jrTarget;
    end else if (jump) begin
      next_pc = jump_target(pcp4_q, jumpIndex);
    end else if (branchTaken) begin
      next_pc = branchTarget;
    end
    if (!redirect) begin
      next_pc = pc_plus4;
    end
  end

  assign pc_hold = (state_q == ST_BOOT) | stall;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .hold_i (pc_hold),
    .pc_d_i (next_pc),
    .pc_o   (pc)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        inst_d  = NOP_INST;
        pcp4_d  = 32'h0;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        // Stall wins over redirect: the ID-stage decision is not final yet.
        if (!stall) begin
          if (redirect) begin
            inst_d  = NOP_INST;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
          end else begin
            inst_d  = instIn;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      inst_q  <= NOP_INST;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign instAddr     = (state_q == ST_BOOT) ? RESET_PC : pc;
  assign ifId_inst    = inst_q;
  assign ifId_pcPlus4 = pcp4_q;
  assign ifId_valid   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else if (state_q == ST_RUN) begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (!stall && redirect && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID outputs are queued per step and
// compared after the clock edge; imem[word i] = i + 1.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic        jumpReg;
  logic [25:0] jumpIndex;
  logic [31:0] jrTarget;
  logic [31:0] instAddr;
  logic [31:0] instIn;
  logic [31:0] ifId_inst;
  logic [31:0] ifId_pcPlus4;
  logic        ifId_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stallCount;
  logic [15:0] flushCount;
`endif

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pcp4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign instIn = (instAddr >> 2) + 32'd1;

  fetch_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpReg      (jumpReg),
    .jumpIndex    (jumpIndex),
    .jrTarget     (jrTarget),
    .instAddr     (instAddr),
    .instIn       (instIn),
    .ifId_inst    (ifId_inst),
    .ifId_pcPlus4 (ifId_pcPlus4),
    .ifId_valid   (ifId_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stallCount   (stallCount),
    .flushCount   (flushCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d: got %h want %h", tag, step_no, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then compare.
  task automatic step(input logic r, input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic jr, input logic [25:0] idx,
                      input logic [31:0] jrt, input logic [31:0] e_addr,
                      input logic e_valid, input logic [31:0] e_inst,
                      input logic [31:0] e_pcp4);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; stall = st; branchTaken = br; branchTarget = bt;
    jump = j; jumpReg = jr; jumpIndex = idx; jrTarget = jrt;
    e.addr = e_addr; e.inst = e_inst; e.pcp4 = e_pcp4; e.valid = e_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    got = exp_q.pop_front();
    check("instAddr", instAddr, got.addr);
    check("ifId_valid", {31'h0, ifId_valid}, {31'h0, got.valid});
    check("ifId_inst", ifId_inst, got.inst);
    check("ifId_pcPlus4", ifId_pcPlus4, got.pcp4);
    $display("step %0d rst=%0b stall=%0b br=%0b j=%0b jr=%0b -> addr=%h valid=%0b inst=%h pc4=%h",
             step_no, r, st, br, j, jr, instAddr, ifId_valid, ifId_inst, ifId_pcPlus4);
  endtask

  task automatic run(input logic [31:0] e_addr, input logic [31:0] e_inst,
                     input logic [31:0] e_pcp4);
    step(0, 0, 0, 0, 0, 0, 0, 0, e_addr, 1, e_inst, e_pcp4);
  endtask

  initial begin
    rst = 1; stall = 0; branchTaken = 0; branchTarget = 0;
    jump = 0; jumpReg = 0; jumpIndex = 0; jrTarget = 0;

    // reset, BOOT cycle, then sequential fetch
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    run(32'h04, 32'd1, 32'h04);
    run(32'h08, 32'd2, 32'h08);
    run(32'h0C, 32'd3, 32'h0C);
    run(32'h10, 32'd4, 32'h10);

    // stall three cycles at PC=0x10; a branch during stall is ignored
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 1, 32'd4, 32'h10);
    step(0, 1, 1, 32'h40, 0, 0, 0, 0, 32'h10, 1, 32'd4, 32'h10);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 1, 32'd4, 32'h10);
    run(32'h14, 32'd5, 32'h14);

    // taken branch to 0x40
    step(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 0, 32'h0, 32'h0);
    run(32'h44, 32'd17, 32'h44);

    // branch to 0x100, then a jump while ID holds a bubble is ignored
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 32'h100, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 26'h10, 0, 32'h104, 1, 32'h41, 32'h104);

    // jump+jumpReg with stall: frozen; without stall: JR wins
    step(0, 1, 0, 0, 1, 1, 26'h10, 32'h80, 32'h104, 1, 32'h41, 32'h104);
    step(0, 0, 0, 0, 1, 1, 26'h10, 32'h80, 32'h80, 0, 32'h0, 32'h0);
    run(32'h84, 32'd33, 32'h84);

    // J target keeps the upper nibble of ifId_pcPlus4
    step(0, 0, 0, 0, 0, 1, 0, 32'hF000_0004, 32'hF000_0004, 0, 32'h0, 32'h0);
    run(32'hF000_0008, 32'h3C00_0002, 32'hF000_0008);
    step(0, 0, 0, 0, 1, 0, 26'h10, 0, 32'hF000_0040, 0, 32'h0, 32'h0);
    run(32'hF000_0044, 32'h3C00_0011, 32'hF000_0044);

    // PC+4 wraps from 0xFFFF_FFFC to 0
    step(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
    run(32'h0, 32'h4000_0000, 32'h0);

    // reset during stall+redirect discards the update; BOOT ignores stall/redirect
    step(1, 1, 1, 32'h200, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    step(0, 1, 1, 32'h200, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    run(32'h04, 32'd1, 32'h04);

    // two stalls then one redirect
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h04, 1, 32'd1, 32'h04);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h04, 1, 32'd1, 32'h04);
    step(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h40, 0, 32'h0, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    check("stallCount", {16'h0, stallCount}, 32'd2);
    check("flushCount", {16'h0, flushCount}, 32'd1);
    @(negedge clk);
    stall = 1; branchTaken = 0;
    for (int i = 0; i < 65540; i++) @(negedge clk);
    check("stallCount_sat", {16'h0, stallCount}, 32'h0000_FFFF);
    check("flushCount_hold", {16'h0, flushCount}, 32'd1);
    stall = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
